// File: rtl/arb_pkg.sv
// rtl/arb_pkg.sv - shared constants, state type and rotating search for the round-robin arbiter
package arb_pkg;

  localparam int NUM_REQ = 4;
  localparam int ID_W    = 2;
  localparam int HOLD_W  = 8;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;

  // Returns {found, index} of the first set request at or after ptr in
  // rotating order. Scanning from the far end lets the nearest hit win.
  function automatic logic [ID_W:0] rr_search(input logic [NUM_REQ-1:0] req,
                                               input logic [ID_W-1:0]    ptr);
    logic [ID_W-1:0] idx;
    rr_search = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = ptr + ID_W'(k);
      if (req[idx]) begin
        rr_search = {1'b1, idx};
      end
    end
  endfunction

endpackage

// File: rtl/grant_decoder.sv
// rtl/grant_decoder.sv - 2-to-4 one-hot grant decoder with enable
module grant_decoder
  import arb_pkg::*;
(
  input  logic [ID_W-1:0]    gnt_id,
  input  logic               gnt_valid,
  output logic [NUM_REQ-1:0] gnt
);

  // One-hot decode of the owner index, all zero while no grant is active.
  always_comb begin
    gnt = '0;
    if (gnt_valid) begin
      gnt[gnt_id] = 1'b1;
    end
  end

endmodule

// File: rtl/rr_grant_arbiter.sv
// rtl/rr_grant_arbiter.sv - four-client round-robin arbiter, optional watchdog under ARB_TIMEOUT_EN
module rr_grant_arbiter
  import arb_pkg::*;
#(
  parameter int MAX_HOLD = 15
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] gnt,
  output logic [ID_W-1:0]    gnt_id,
  output logic               gnt_valid,
  output logic               timeout
);

  arb_state_t      r_state;
  arb_state_t      w_state_nxt;
  logic [ID_W-1:0] r_ptr;
  logic [ID_W-1:0] w_ptr_nxt;
  logic [ID_W-1:0] r_owner;
  logic [ID_W-1:0] w_owner_nxt;
  logic [ID_W:0]   w_pick;
  logic            w_owner_req;

  assign w_pick      = rr_search(req, r_ptr);
  assign w_owner_req = req[r_owner];

`ifdef ARB_TIMEOUT_EN
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

  logic [HOLD_W-1:0] r_hold_cnt;
  logic [HOLD_W-1:0] w_hold_nxt;
  logic              r_timeout;
  logic              w_revoke;
`endif

  // State, pointer, owner (and watchdog) registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_ptr      <= '0;
      r_owner    <= '0;
`ifdef ARB_TIMEOUT_EN
      r_hold_cnt <= '0;
      r_timeout  <= 1'b0;
`endif
    end else begin
      r_state    <= w_state_nxt;
      r_ptr      <= w_ptr_nxt;
      r_owner    <= w_owner_nxt;
`ifdef ARB_TIMEOUT_EN
      r_hold_cnt <= w_hold_nxt;
      r_timeout  <= w_revoke;
`endif
    end
  end

  // Next-state logic: arbitrate in IDLE, hold until release (or revoke) in GRANT.
  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    w_owner_nxt = r_owner;
`ifdef ARB_TIMEOUT_EN
    w_hold_nxt  = r_hold_cnt;
    w_revoke    = 1'b0;
`endif
    case (r_state)
      IDLE: begin
        if (w_pick[ID_W]) begin
          w_state_nxt = GRANT;
          w_owner_nxt = w_pick[ID_W-1:0];
`ifdef ARB_TIMEOUT_EN
          w_hold_nxt  = '0;
`endif
        end
      end
      GRANT: begin
        // A voluntary release wins over a revoke on the same edge.
        if (!w_owner_req) begin
          w_state_nxt = IDLE;
          w_ptr_nxt   = r_owner + ID_W'(1);
        end
`ifdef ARB_TIMEOUT_EN
        else if (r_hold_cnt == HOLD_LAST) begin
          w_state_nxt = IDLE;
          w_ptr_nxt   = r_owner + ID_W'(1);
          w_revoke    = 1'b1;
        end else begin
          w_hold_nxt  = r_hold_cnt + HOLD_W'(1);
        end
`endif
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  assign gnt_id    = r_owner;
  assign gnt_valid = (r_state == GRANT);

`ifdef ARB_TIMEOUT_EN
  assign timeout = r_timeout;
`else
  // MAX_HOLD only shapes the watchdog; without it the pulse is constant zero.
  assign timeout = 1'b0 & (MAX_HOLD > 255);
`endif

  grant_decoder u_grant_decoder (
    .gnt_id    (r_owner),
    .gnt_valid (gnt_valid),
    .gnt       (gnt)
  );

endmodule

// File: tb/tb_rr_grant_arbiter.sv
// tb/tb_rr_grant_arbiter.sv - self-checking bench for rr_grant_arbiter
module tb_rr_grant_arbiter;

  localparam int TB_MAX_HOLD = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] req = 4'b0000;
  logic [3:0] gnt;
  logic [1:0] gnt_id;
  logic       gnt_valid;
  logic       timeout;

  int total = 0;
  int bad   = 0;
  bit chk_on = 1'b0;

  // reference model state
  int m_owner = -1;
  int m_ptr   = 0;
  int m_id    = 0;
  int m_hold  = 0;
  bit m_to    = 1'b0;
  int m_c;
  logic [3:0] rq;

  always #5 clk = ~clk;

  rr_grant_arbiter #(.MAX_HOLD(TB_MAX_HOLD)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .gnt       (gnt),
    .gnt_id    (gnt_id),
    .gnt_valid (gnt_valid),
    .timeout   (timeout)
  );

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %0h want %0h", nm, $time, act, exp);
    end
  endtask

  // Behavioural model: owner -1 means nobody holds the resource.
  always @(posedge clk) begin
    if (rst) begin
      m_owner = -1; m_ptr = 0; m_id = 0; m_hold = 0; m_to = 1'b0;
    end else begin
      m_to = 1'b0;
      if (m_owner < 0) begin
        for (int k = 0; k < 4; k++) begin
          m_c = (m_ptr + k) % 4;
          if (m_owner < 0 && req[m_c]) begin
            m_owner = m_c; m_id = m_c; m_hold = 0;
          end
        end
      end else if (!req[m_owner]) begin
        m_ptr = (m_owner + 1) % 4; m_owner = -1;
      end
`ifdef ARB_TIMEOUT_EN
      else if (m_hold + 1 >= TB_MAX_HOLD) begin
        m_ptr = (m_owner + 1) % 4; m_owner = -1; m_to = 1'b1;
      end else begin
        m_hold++;
      end
`endif
    end
  end

  // Compare process: every cycle away from the active edge.
  always @(negedge clk) begin
    if (chk_on) begin
      cmp("gnt", {28'd0, gnt}, (m_owner >= 0) ? (32'd1 << m_owner) : 32'd0);
      cmp("gnt_valid", {31'd0, gnt_valid}, {31'd0, m_owner >= 0});
      cmp("gnt_id", {30'd0, gnt_id}, m_id);
      cmp("timeout", {31'd0, timeout}, {31'd0, m_to});
    end
  end

  task automatic step(input logic [3:0] r, input logic rs);
    req = r;
    rst = rs;
    @(negedge clk);
  endtask

  initial begin
    // reset with all requesting
    step(4'b1111, 1'b1);
    chk_on = 1'b1;
    cmp("rst_gnt", {28'd0, gnt}, 0); cmp("rst_valid", {31'd0, gnt_valid}, 0); cmp("rst_to", {31'd0, timeout}, 0);
    step(4'b1111, 1'b1);
    cmp("rst_gnt2", {28'd0, gnt}, 0); cmp("rst_valid2", {31'd0, gnt_valid}, 0); cmp("rst_id2", {30'd0, gnt_id}, 0);

    // single client, then pointer lands on 3
    step(4'b0100, 1'b0);
    cmp("single_gnt", {28'd0, gnt}, 32'h4); cmp("single_id", {30'd0, gnt_id}, 2);
    step(4'b0000, 1'b0);
    cmp("single_rel", {28'd0, gnt}, 0); cmp("idle_keeps_id", {30'd0, gnt_id}, 2);
    step(4'b0000, 1'b0);
    step(4'b1111, 1'b0);
    cmp("ptr3_gnt", {28'd0, gnt}, 32'h8);
    step(4'b0000, 1'b0);

    // fairness: 0,1,2,3,0 with one idle cycle between grants
    for (int e = 0; e < 5; e++) begin
      step(4'b1111, 1'b0);
      cmp("fair_gnt", {28'd0, gnt}, 32'd1 << (e % 4));
      step(4'b1111, 1'b0);
      cmp("fair_hold", {28'd0, gnt}, 32'd1 << (e % 4));
      step(4'b1111 & ~(4'b0001 << (e % 4)), 1'b0);
      cmp("fair_idle", {28'd0, gnt}, 0);
    end

    // no preemption while client 1 holds
    step(4'b0010, 1'b0);
    cmp("np_gnt1", {28'd0, gnt}, 32'h2);
    for (int i = 0; i < 3; i++) begin
      step(4'b1011, 1'b0);
      cmp("np_hold", {28'd0, gnt}, 32'h2);
    end
    step(4'b1001, 1'b0);
    cmp("np_rel", {28'd0, gnt}, 0);
    step(4'b1011, 1'b0);
    cmp("np_next3", {28'd0, gnt}, 32'h8);
    step(4'b0000, 1'b0);

    // reset in the middle of a grant
    step(4'b0100, 1'b0);
    cmp("mid_gnt2", {28'd0, gnt}, 32'h4);
    step(4'b0100, 1'b1);
    cmp("mid_rst", {28'd0, gnt}, 0);
    step(4'b0110, 1'b0);
    cmp("post_rst", {28'd0, gnt}, 32'h2);
    step(4'b0000, 1'b0);

`ifdef ARB_TIMEOUT_EN
    // watchdog with MAX_HOLD=4
    for (int i = 0; i < 4; i++) begin
      step(4'b0001, 1'b0);
      cmp("wd_hold", {28'd0, gnt}, 32'h1);
    end
    step(4'b0001, 1'b0);
    cmp("wd_to", {31'd0, timeout}, 1); cmp("wd_gnt0", {28'd0, gnt}, 0);
    step(4'b0001, 1'b0);
    cmp("wd_regnt", {28'd0, gnt}, 32'h1); cmp("wd_to_low", {31'd0, timeout}, 0);
    step(4'b0000, 1'b0);
`endif

    // randomized traffic with occasional reset
    rq = 4'b0000;
    for (int i = 0; i < 3000; i++) begin
      for (int b = 0; b < 4; b++) begin
        if ($urandom_range(3) == 0) rq[b] = ~rq[b];
      end
      step(rq, ($urandom_range(63) == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
